// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - serial-loaded, double-buffered multi-colour segment/LED scan driver
// Optional macro BRIGHTNESS_EN: frame gains a trailing 4-bit brightness field that PWM-gates lit slots.
module seg_scan_driver #(
    parameter int SEGS     = 7,
    parameter int COLORS   = 2,
    parameter int LEDS     = 7,
    parameter int SCAN_DIV = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ser_clk,
    input  logic                        ser_data,
    input  logic                        ser_latch,
    output logic [COLORS*SEGS+LEDS-1:0] leds,
    output logic [$clog2(SEGS)-1:0]     seg_idx,
    output logic                        frame_ok,
    output logic                        frame_err
);
    localparam int PIX_W = COLORS*SEGS+LEDS;
`ifdef BRIGHTNESS_EN
    localparam int FRAME_W = PIX_W + 4;
    localparam logic [FRAME_W-1:0] ACT_RST = FRAME_W'(4'hF);
`else
    localparam int FRAME_W = PIX_W;
    localparam logic [FRAME_W-1:0] ACT_RST = '0;
`endif
    localparam int CNT_W = $clog2(FRAME_W+2);
    localparam int SEG_W = $clog2(SEGS);
    localparam int COL_W = (COLORS > 1) ? $clog2(COLORS) : 1;
    localparam int LID_W = (LEDS > 1) ? $clog2(LEDS) : 1;

    logic [2:0]         r_sclk_sync;
    logic [2:0]         r_latch_sync;
    logic [1:0]         r_data_sync;
    logic               w_sclk_rise;
    logic               w_latch_rise;

    logic [FRAME_W-1:0] r_sr;
    logic [FRAME_W-1:0] r_shadow;
    logic [FRAME_W-1:0] r_active;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pending;
    logic               r_ok;
    logic               r_err;
    logic [FRAME_W-1:0] w_sr_next;
    logic [CNT_W-1:0]   w_cnt_next;

    logic [SCAN_DIV-1:0] r_cyc;
    logic               r_blank;
    logic [COL_W-1:0]   r_col;
    logic [LID_W-1:0]   r_lid;
    logic [SEG_W-1:0]   r_seg;
    logic               w_slot_end;
    logic               w_blank_next;
    logic [COL_W-1:0]   w_col_next;
    logic [LID_W-1:0]   w_lid_next;
    logic [SEG_W-1:0]   w_seg_next;
    logic [SEGS-1:0]    w_seg_oh;
    logic [LEDS-1:0]    w_led_oh;
    logic [FRAME_W-1:0] w_act_next;
    logic [PIX_W-1:0]   w_mask;
    logic [PIX_W-1:0]   w_pattern;
    logic [PIX_W-1:0]   r_leds;

    assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_latch_rise = r_latch_sync[1] & ~r_latch_sync[2];
    // A shift edge coinciding with a latch edge is folded in before the count is judged.
    assign w_sr_next    = w_sclk_rise ? {r_sr[FRAME_W-2:0], r_data_sync[1]} : r_sr;
    assign w_cnt_next   = (w_sclk_rise && (r_cnt != CNT_W'(FRAME_W+1))) ? r_cnt + 1'b1 : r_cnt;

    assign w_slot_end   = &r_cyc;
    assign w_act_next   = (w_slot_end && r_pending) ? r_shadow : r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync  <= '0;
            r_latch_sync <= '0;
            r_data_sync  <= '0;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[1:0], ser_clk};
            r_latch_sync <= {r_latch_sync[1:0], ser_latch};
            r_data_sync  <= {r_data_sync[0], ser_data};
            r_sr         <= w_sr_next;
            r_ok         <= 1'b0;
            if (w_slot_end) begin
                r_pending <= 1'b0;
            end
            if (w_latch_rise) begin
                r_cnt <= '0;
                if (w_cnt_next == CNT_W'(FRAME_W)) begin
                    r_shadow  <= w_sr_next;
                    r_pending <= 1'b1;
                    r_ok      <= 1'b1;
                    r_err     <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    // Slot order per segment: plane COLORS-1 LEDs 0..LEDS-1, ..., plane 0, then one blank slot.
    always_comb begin
        w_blank_next = 1'b0;
        w_col_next   = r_col;
        w_lid_next   = r_lid;
        w_seg_next   = r_seg;
        if (r_blank) begin
            w_col_next = COL_W'(COLORS-1);
            w_lid_next = '0;
            w_seg_next = (r_seg == SEG_W'(SEGS-1)) ? '0 : r_seg + 1'b1;
        end else if (r_lid == LID_W'(LEDS-1)) begin
            w_lid_next = '0;
            if (r_col == '0) begin
                w_blank_next = 1'b1;
            end else begin
                w_col_next = r_col - 1'b1;
            end
        end else begin
            w_lid_next = r_lid + 1'b1;
        end
    end

    assign w_seg_oh = SEGS'(1) << w_seg_next;
    assign w_led_oh = LEDS'(1) << w_lid_next;

    always_comb begin
        w_mask = '0;
        for (int c = 0; c < COLORS; c++) begin
            if (w_col_next == COL_W'(c)) begin
                w_mask[LEDS + c*SEGS +: SEGS] = w_seg_oh;
            end
        end
        w_mask[LEDS-1:0] = w_led_oh;
        w_pattern = w_blank_next ? '0 : (w_act_next[FRAME_W-1 -: PIX_W] & w_mask);
    end

`ifdef BRIGHTNESS_EN
    localparam int ON_W = SCAN_DIV + 1;
    logic [PIX_W-1:0]    r_pattern;
    logic [SCAN_DIV-1:0] w_cyc_next;
    logic [ON_W-1:0]     w_on_len;

    assign w_cyc_next = r_cyc + 1'b1;
    assign w_on_len   = ON_W'({1'b0, w_act_next[3:0]} + 5'd1) << (SCAN_DIV-4);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc    <= '0;
            r_blank  <= 1'b0;
            r_col    <= COL_W'(COLORS-1);
            r_lid    <= '0;
            r_seg    <= '0;
            r_active <= ACT_RST;
            r_leds   <= '0;
`ifdef BRIGHTNESS_EN
            r_pattern <= '0;
`endif
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (w_slot_end) begin
                r_blank  <= w_blank_next;
                r_col    <= w_col_next;
                r_lid    <= w_lid_next;
                r_seg    <= w_seg_next;
                r_active <= w_act_next;
            end
`ifdef BRIGHTNESS_EN
            if (w_slot_end) begin
                r_pattern <= w_pattern;
            end
            if ({1'b0, w_cyc_next} < w_on_len) begin
                r_leds <= w_slot_end ? w_pattern : r_pattern;
            end else begin
                r_leds <= '0;
            end
`else
            if (w_slot_end) begin
                r_leds <= w_pattern;
            end
`endif
        end
    end

    assign leds      = r_leds;
    assign seg_idx   = r_seg;
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
endmodule
